// File: rtl/apb_master_bridge.sv
// Bridges a single-outstanding core load/store request onto APB-style setup/access
// transfers, returning read data and error (slave perr or access timeout) as a one-cycle pulse.
module apb_master_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   input  logic                  ready,
   input  logic                  perr
);

   localparam int unsigned       CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t                  r_state;
   logic [CW-1:0]           r_cnt;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [ADDR_WIDTH-1:0]   r_paddr;
   logic [DATA_WIDTH-1:0]   r_pdata;
   logic [3:0]              r_pstb;
   logic                    r_rsp_valid;
   logic                    r_rsp_err;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;

   // presetn gates req_ready so no request is acknowledged while reset is asserted
   assign req_ready = (r_state == IDLE) && presetn;

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pdata     = r_pdata;
   assign pstb      = r_pstb;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pdata     <= '0;
         r_pstb      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_paddr   <= req_addr;
                  r_pdata   <= req_wdata;
                  r_pstb    <= req_wstrb;
                  r_pwrite  <= req_write;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_state   <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (ready) begin
                  r_rsp_rdata <= r_pwrite ? '0 : prdata;
                  r_rsp_err   <= perr;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_psel    <= 1'b0;
               r_penable <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

endmodule
